// File: rtl/rtc_bus_cycle.sv
// rtc_bus_cycle: Intel-mode address/data bus-cycle engine for the V3023 RTC.
// One start request runs an address write transfer followed by a data write or read.
module rtc_bus_cycle #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 4,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_GAP   = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic       rd_nwr,
  input  logic [7:0] din,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       A_D,
  output logic       CS,
  output logic       WR,
  output logic       RD,
  output logic       sent_a,
  output logic       sent_d,
  output logic       fin,
  output logic       busy,
  output logic [7:0] rd_data
);

  localparam int unsigned CNT_W = 8;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(T_GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_A_SETUP,
    S_A_STROBE,
    S_A_HOLD,
    S_GAP,
    S_D_SETUP,
    S_D_STROBE,
    S_D_HOLD,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic             rd_nwr_q, rd_nwr_d;
  logic             cnt_zero;
  logic             capture;
  logic             ad_oe_d, a_d_d, cs_d, wr_d, rd_d;
  logic             sent_a_d, sent_d_d, fin_d, busy_d;

  assign cnt_zero = (cnt_q == '0);
  assign cnt_dec  = cnt_q - CNT_W'(1);
  // Read data is sampled on the edge that ends the read strobe, while RD is still low.
  assign capture  = (state_q == S_D_STROBE) && cnt_zero && rd_nwr_q;

  // The upstream FSM may switch din on sent_a/sent_d, so the bus drive follows din directly.
  assign ad_out = ad_oe ? din : 8'h00;

  // Next state, phase counter, and control outputs decoded from the next state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_nwr_d = rd_nwr_q;
    ad_oe_d  = 1'b0;
    a_d_d    = 1'b1;
    cs_d     = 1'b1;
    wr_d     = 1'b1;
    rd_d     = 1'b1;
    sent_a_d = 1'b0;
    sent_d_d = 1'b0;
    fin_d    = 1'b0;
    busy_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_nwr_d = rd_nwr;
          state_d  = S_A_SETUP;
          cnt_d    = LD_SETUP;
        end
      end
      S_A_SETUP: begin
        if (cnt_zero) begin state_d = S_A_STROBE; cnt_d = LD_PULSE; end
        else cnt_d = cnt_dec;
      end
      S_A_STROBE: begin
        if (cnt_zero) begin state_d = S_A_HOLD; cnt_d = LD_HOLD; end
        else cnt_d = cnt_dec;
      end
      S_A_HOLD: begin
        if (cnt_zero) begin state_d = S_GAP; cnt_d = LD_GAP; end
        else cnt_d = cnt_dec;
      end
      S_GAP: begin
        if (cnt_zero) begin state_d = S_D_SETUP; cnt_d = LD_SETUP; end
        else cnt_d = cnt_dec;
      end
      S_D_SETUP: begin
        if (cnt_zero) begin state_d = S_D_STROBE; cnt_d = LD_PULSE; end
        else cnt_d = cnt_dec;
      end
      S_D_STROBE: begin
        if (cnt_zero) begin state_d = S_D_HOLD; cnt_d = LD_HOLD; end
        else cnt_d = cnt_dec;
      end
      S_D_HOLD: begin
        if (cnt_zero) begin state_d = S_DONE; cnt_d = '0; end
        else cnt_d = cnt_dec;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);

    case (state_d)
      S_A_SETUP, S_A_HOLD: begin
        cs_d = 1'b0; a_d_d = 1'b0; sent_a_d = 1'b1; ad_oe_d = 1'b1;
      end
      S_A_STROBE: begin
        cs_d = 1'b0; a_d_d = 1'b0; sent_a_d = 1'b1; ad_oe_d = 1'b1; wr_d = 1'b0;
      end
      S_D_SETUP, S_D_HOLD: begin
        cs_d = 1'b0; sent_d_d = 1'b1; ad_oe_d = ~rd_nwr_d;
      end
      S_D_STROBE: begin
        cs_d = 1'b0; sent_d_d = 1'b1; ad_oe_d = ~rd_nwr_d;
        if (rd_nwr_d) rd_d = 1'b0;
        else          wr_d = 1'b0;
      end
      S_DONE:  fin_d = 1'b1;
      default: ;
    endcase
  end

  // State, counter, latched transfer type, control outputs and read capture.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rd_nwr_q <= 1'b0;
      ad_oe    <= 1'b0;
      A_D      <= 1'b1;
      CS       <= 1'b1;
      WR       <= 1'b1;
      RD       <= 1'b1;
      sent_a   <= 1'b0;
      sent_d   <= 1'b0;
      fin      <= 1'b0;
      busy     <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_nwr_q <= rd_nwr_d;
      ad_oe    <= ad_oe_d;
      A_D      <= a_d_d;
      CS       <= cs_d;
      WR       <= wr_d;
      RD       <= rd_d;
      sent_a   <= sent_a_d;
      sent_d   <= sent_d_d;
      fin      <= fin_d;
      busy     <= busy_d;
      if (capture) rd_data <= ad_in;
    end
  end

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Bench for rtc_bus_cycle: default-timing and all-ones-timing instances share stimulus;
// both are compared every cycle against a timeline model, plus a table of directed vectors.
module tb_rtc_bus_cycle;

  logic       Clock = 1'b0;
  logic       Reset, start, rd_nwr;
  logic [7:0] din, ad_in;

  logic [7:0] ad_out0, rd_data0, ad_out1, rd_data1;
  logic       ad_oe0, A_D0, CS0, WR0, RD0, sent_a0, sent_d0, fin0, busy0;
  logic       ad_oe1, A_D1, CS1, WR1, RD1, sent_a1, sent_d1, fin1, busy1;

  rtc_bus_cycle dut0 (
    .Clock(Clock), .Reset(Reset), .start(start), .rd_nwr(rd_nwr), .din(din), .ad_in(ad_in),
    .ad_out(ad_out0), .ad_oe(ad_oe0), .A_D(A_D0), .CS(CS0), .WR(WR0), .RD(RD0),
    .sent_a(sent_a0), .sent_d(sent_d0), .fin(fin0), .busy(busy0), .rd_data(rd_data0)
  );

  rtc_bus_cycle #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .start(start), .rd_nwr(rd_nwr), .din(din), .ad_in(ad_in),
    .ad_out(ad_out1), .ad_oe(ad_oe1), .A_D(A_D1), .CS(CS1), .WR(WR1), .RD(RD1),
    .sent_a(sent_a1), .sent_d(sent_d1), .fin(fin1), .busy(busy1), .rd_data(rd_data1)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       oe, a_d, cs, wr, rd, sa, sd, fin, busy;
    logic [7:0] ad_out;
    logic [7:0] rd_data;
  } obs_t;

  typedef struct {
    int         id;
    int         cyc;
    logic       wr, rd, a_d, cs, oe, fin, busy;
    logic [7:0] ad_out;
    logic [7:0] rd_data;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int p_ts[2], p_tp[2], p_th[2], p_tg[2];
  int m_ofs[2];
  logic m_rd[2];
  logic [7:0] m_rdata[2];
  vec_t vt[$];
  int fin0_q[$], fin1_q[$], idle0_q[$];
  int wr1_low;

  // Model: a cycle is a timeline of offsets 1..F after the accepted start edge.
  function automatic int a_len(int m);
    return p_ts[m] + p_tp[m] + p_th[m];
  endfunction

  function automatic int fin_ofs(int m);
    return 2 * a_len(m) + p_tg[m] + 1;
  endfunction

  function automatic logic in_strobe(int m, int p);
    return (p > p_ts[m]) && (p <= p_ts[m] + p_tp[m]);
  endfunction

  function automatic obs_t model_obs(int m);
    obs_t e;
    int o, p;
    o = m_ofs[m];
    p = o - a_len(m) - p_tg[m];
    e.oe = 1'b0; e.a_d = 1'b1; e.cs = 1'b1; e.wr = 1'b1; e.rd = 1'b1;
    e.sa = 1'b0; e.sd = 1'b0; e.fin = 1'b0; e.busy = (o != 0);
    e.rd_data = m_rdata[m];
    if (o >= 1 && o <= a_len(m)) begin
      e.cs = 1'b0; e.a_d = 1'b0; e.sa = 1'b1; e.oe = 1'b1;
      if (in_strobe(m, o)) e.wr = 1'b0;
    end else if (p >= 1 && p <= a_len(m)) begin
      e.cs = 1'b0; e.sd = 1'b1; e.oe = !m_rd[m];
      if (in_strobe(m, p)) begin
        if (m_rd[m]) e.rd = 1'b0;
        else         e.wr = 1'b0;
      end
    end else if (o == fin_ofs(m)) begin
      e.fin = 1'b1;
    end
    e.ad_out = e.oe ? din : 8'h00;
    return e;
  endfunction

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      if (Reset) begin
        m_ofs[m] = 0; m_rd[m] = 1'b0; m_rdata[m] = 8'h00;
      end else begin
        int p;
        p = m_ofs[m] - a_len(m) - p_tg[m];
        if (m_rd[m] && p == p_ts[m] + p_tp[m]) m_rdata[m] = ad_in;
        if (m_ofs[m] == 0) begin
          if (start) begin m_ofs[m] = 1; m_rd[m] = rd_nwr; end
        end else if (m_ofs[m] == fin_ofs(m)) begin
          m_ofs[m] = 0;
        end else begin
          m_ofs[m] = m_ofs[m] + 1;
        end
      end
    end
  endtask

  function automatic obs_t get_obs(int m);
    obs_t g;
    if (m == 0) g = '{ad_oe0, A_D0, CS0, WR0, RD0, sent_a0, sent_d0, fin0, busy0, ad_out0, rd_data0};
    else        g = '{ad_oe1, A_D1, CS1, WR1, RD1, sent_a1, sent_d1, fin1, busy1, ad_out1, rd_data1};
    return g;
  endfunction

  function automatic obs_t rst_obs();
    obs_t r;
    r = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    return r;
  endfunction

  task automatic cmp(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic cmp_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic vec_t mkv(int id, int c, logic wr, logic rd, logic a_d, logic cs, logic oe,
                               logic f, logic b, logic [7:0] ao, logic [7:0] rdd);
    vec_t v;
    v.id = id; v.cyc = c; v.wr = wr; v.rd = rd; v.a_d = a_d; v.cs = cs; v.oe = oe;
    v.fin = f; v.busy = b; v.ad_out = ao; v.rd_data = rdd;
    return v;
  endfunction

  function automatic logic [7:0] din_for(int c);
    if (c >= 1 && c <= 8)   return 8'h02;
    if (c >= 11 && c <= 18) return 8'h10;
    return 8'h5A;
  endfunction

  function automatic logic [7:0] adin_for(int c);
    return (c >= 13 && c <= 16) ? 8'h37 : 8'hFF;
  endfunction

  task automatic check_table(input int id);
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].id == id && vt[i].cyc == cyc) begin
        logic [22:0] g, e;
        g = {WR0, RD0, A_D0, CS0, ad_oe0, fin0, busy0, ad_out0, rd_data0};
        e = {vt[i].wr, vt[i].rd, vt[i].a_d, vt[i].cs, vt[i].oe, vt[i].fin, vt[i].busy,
             vt[i].ad_out, vt[i].rd_data};
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL vec id=%0d cyc=%0d got=%h exp=%h", id, cyc, g, e);
        end
      end
    end
  endtask

  // One clock: model follows the edge, outputs are compared mid-cycle.
  task automatic next_cycle(input logic rnd_data);
    @(posedge Clock);
    model_edge();
    @(negedge Clock);
    cyc = cyc + 1;
    if (rnd_data) begin
      din = 8'($urandom); ad_in = 8'($urandom);
    end else begin
      din = din_for(cyc); ad_in = adin_for(cyc);
    end
    #1;
    cmp("model_dut0", get_obs(0), model_obs(0));
    cmp("model_dut1", get_obs(1), model_obs(1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0; Reset = 1'b0;
      next_cycle(1'b0);
    end
  endtask

  task automatic run_dir(input int id, input logic rdm, input int ncyc, input int hold_to,
                         input int pulse_at, input int rlo, input int rhi);
    fin0_q.delete(); fin1_q.delete(); idle0_q.delete();
    wr1_low = 0;
    cyc = 0;
    din = din_for(0); ad_in = adin_for(0);
    while (cyc < ncyc) begin
      start  = (cyc <= hold_to) || (cyc == pulse_at);
      rd_nwr = rdm;
      Reset  = (cyc >= rlo) && (cyc <= rhi);
      next_cycle(1'b0);
      check_table(id);
      if (fin0 === 1'b1) fin0_q.push_back(cyc);
      if (fin1 === 1'b1) fin1_q.push_back(cyc);
      if (busy0 === 1'b0 && cyc < ncyc) idle0_q.push_back(cyc);
      if (WR1 === 1'b0) wr1_low++;
    end
    start = 1'b0; Reset = 1'b0;
  endtask

  initial begin
    p_ts[0] = 2; p_tp[0] = 4; p_th[0] = 2; p_tg[0] = 2;
    p_ts[1] = 1; p_tp[1] = 1; p_th[1] = 1; p_tg[1] = 1;
    for (int m = 0; m < 2; m++) begin m_ofs[m] = 0; m_rd[m] = 1'b0; m_rdata[m] = 8'h00; end

    // id 0: default write, din 02 in address phase and 10 in data phase
    vt.push_back(mkv(0,  1, 1,1,0,0,1,0,1, 8'h02, 8'h00));
    vt.push_back(mkv(0,  2, 1,1,0,0,1,0,1, 8'h02, 8'h00));
    vt.push_back(mkv(0,  3, 0,1,0,0,1,0,1, 8'h02, 8'h00));
    vt.push_back(mkv(0,  6, 0,1,0,0,1,0,1, 8'h02, 8'h00));
    vt.push_back(mkv(0,  7, 1,1,0,0,1,0,1, 8'h02, 8'h00));
    vt.push_back(mkv(0,  9, 1,1,1,1,0,0,1, 8'h00, 8'h00));
    vt.push_back(mkv(0, 12, 1,1,1,0,1,0,1, 8'h10, 8'h00));
    vt.push_back(mkv(0, 13, 0,1,1,0,1,0,1, 8'h10, 8'h00));
    vt.push_back(mkv(0, 16, 0,1,1,0,1,0,1, 8'h10, 8'h00));
    vt.push_back(mkv(0, 17, 1,1,1,0,1,0,1, 8'h10, 8'h00));
    vt.push_back(mkv(0, 18, 1,1,1,0,1,0,1, 8'h10, 8'h00));
    vt.push_back(mkv(0, 19, 1,1,1,1,0,1,1, 8'h00, 8'h00));
    vt.push_back(mkv(0, 20, 1,1,1,1,0,0,0, 8'h00, 8'h00));
    // id 1: default read, ad_in 37 only during the read strobe
    vt.push_back(mkv(1,  3, 0,1,0,0,1,0,1, 8'h02, 8'h00));
    vt.push_back(mkv(1, 12, 1,1,1,0,0,0,1, 8'h00, 8'h00));
    vt.push_back(mkv(1, 13, 1,0,1,0,0,0,1, 8'h00, 8'h00));
    vt.push_back(mkv(1, 16, 1,0,1,0,0,0,1, 8'h00, 8'h00));
    vt.push_back(mkv(1, 17, 1,1,1,0,0,0,1, 8'h00, 8'h37));
    vt.push_back(mkv(1, 19, 1,1,1,1,0,1,1, 8'h00, 8'h37));
    vt.push_back(mkv(1, 22, 1,1,1,1,0,0,0, 8'h00, 8'h37));

    Reset = 1'b1; start = 1'b0; rd_nwr = 1'b0; din = 8'h00; ad_in = 8'h00;
    for (int i = 0; i < 3; i++) next_cycle(1'b0);
    cmp("reset_dut0", get_obs(0), rst_obs());
    cmp("reset_dut1", get_obs(1), rst_obs());
    Reset = 1'b0;
    idle(2);

    run_dir(0, 1'b0, 20, 0, -1, -1, -1);
    cmp_int("write_fin0_count", fin0_q.size(), 1);
    cmp_int("write_fin0_cycle", fin0_q.size() > 0 ? fin0_q[0] : -1, 19);
    cmp_int("t1_fin_cycle", fin1_q.size() > 0 ? fin1_q[0] : -1, 8);
    cmp_int("t1_wr_low_cycles", wr1_low, 2);
    idle(5);

    run_dir(1, 1'b1, 22, 0, -1, -1, -1);
    cmp_int("read_fin0_cycle", fin0_q.size() > 0 ? fin0_q[0] : -1, 19);
    idle(5);

    run_dir(2, 1'b0, 30, 0, 5, -1, -1);
    cmp_int("busy_start_fin0_count", fin0_q.size(), 1);
    cmp_int("busy_start_fin1_count", fin1_q.size(), 1);
    idle(5);

    run_dir(4, 1'b0, 40, 39, -1, -1, -1);
    cmp_int("held_fin_count", fin0_q.size(), 2);
    cmp_int("held_fin_first", fin0_q.size() > 0 ? fin0_q[0] : -1, 19);
    cmp_int("held_fin_second", fin0_q.size() > 1 ? fin0_q[1] : -1, 39);
    cmp_int("held_idle_count", idle0_q.size(), 1);
    cmp_int("held_idle_cycle", idle0_q.size() > 0 ? idle0_q[0] : -1, 20);
    idle(20);

    run_dir(3, 1'b1, 17, 0, -1, 14, 16);
    cmp("midreset_dut0", get_obs(0), rst_obs());
    cmp("midreset_dut1", get_obs(1), rst_obs());
    idle(3);
    cmp("after_reset_dut0", get_obs(0), rst_obs());

    for (int i = 0; i < 4000; i++) begin
      start  = ($urandom_range(0, 3) == 0);
      rd_nwr = 1'($urandom);
      Reset  = ($urandom_range(0, 199) == 0);
      next_cycle(1'b1);
    end
    Reset = 1'b0; start = 1'b0;
    idle(25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
